vga_rx_decoder: RTL and testbench

- Receiving end of the team's 640x480@60 VGA link: samples HS/VS/BLANK_N/RGB from the VGA timing generator (or an external source on the same pixel clock) and recovers pixel coordinates.
- Checks the incoming timing against the nominal mode and reports lock.
- Emits a validated pixel stream with x/y, start-of-frame and end-of-line strobes for frame capture and loopback checking.

---
 rtl/vga_rx_decoder.sv | 183 ++++++++++++++++++
 tb/tb_vga_rx_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_decoder.sv
// VGA receive-side timing decoder: recovers pixel coordinates from HS/VS/BLANK_N,
// checks line and frame timing against the nominal mode, and reports lock.
module vga_rx_decoder #(
    parameter int unsigned WIDTH   = 640,
    parameter int unsigned HEIGHT  = 480,
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned CNT_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hs,
    input  logic             i_vs,
    input  logic             i_blank_n,
    input  logic [7:0]       i_r,
    input  logic [7:0]       i_g,
    input  logic [7:0]       i_b,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic [7:0]       o_r,
    output logic [7:0]       o_g,
    output logic [7:0]       o_b,
    output logic             o_sof,
    output logic             o_eol,
    output logic             o_locked,
    output logic [7:0]       o_err_cnt
);

    localparam logic [CNT_W-1:0] WidthC   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] LastXC   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] HeightC  = CNT_W'(HEIGHT);
    localparam logic [CNT_W-1:0] HPeriodC = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] OneC     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MaxC     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {S_SEARCH, S_ACQ, S_LOCK} state_t;

    state_t state_q, state_d;

    logic             hs_q, vs_q, de_q;
    logic             hs_fall, vs_fall, de_rise, de_fall;
    logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
    logic [CNT_W-1:0] y_cnt_q, y_cnt_d, y_line;
    logic [CNT_W-1:0] h_per_q, h_per_d;
    logic             h_seen_q, h_seen_d;
    logic             frame_bad_q, frame_bad_d;
    logic             line_err, frame_ok, lock_loss;
    logic [CNT_W-1:0] px, py;
    logic             pix_valid, pix_sof, pix_eol;

    // Edge detection, coordinate/period counters and timing checks
    always_comb begin
        hs_fall = hs_q & ~i_hs;
        vs_fall = vs_q & ~i_vs;
        de_rise = ~de_q & i_blank_n;
        de_fall = de_q & ~i_blank_n;

        px = de_rise ? '0 : x_cnt_q;
        // A pixel sampled together with the VS fall already belongs to row 0
        py = vs_fall ? '0 : y_cnt_q;

        x_cnt_d = x_cnt_q;
        if (de_rise) begin
            x_cnt_d = OneC;
        end else if (i_blank_n && (x_cnt_q != MaxC)) begin
            x_cnt_d = x_cnt_q + OneC;
        end

        // The line ending on this cycle is counted before any frame check sees y
        y_line = (de_fall && (y_cnt_q != MaxC)) ? y_cnt_q + OneC : y_cnt_q;
        y_cnt_d = vs_fall ? '0 : y_line;

        h_per_d = h_per_q;
        if (hs_fall) begin
            h_per_d = '0;
        end else if (h_per_q != MaxC) begin
            h_per_d = h_per_q + OneC;
        end
        h_seen_d = h_seen_q | hs_fall;

        line_err = (hs_fall && h_seen_q && (h_per_q != HPeriodC)) ||
                   (de_fall && (x_cnt_q != WidthC));

        frame_ok    = (y_line == HeightC) && !(frame_bad_q || line_err);
        frame_bad_d = vs_fall ? 1'b0 : (frame_bad_q | line_err);
    end

    // Input sample history and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            de_q        <= 1'b0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            h_per_q     <= '0;
            h_seen_q    <= 1'b0;
            frame_bad_q <= 1'b0;
        end else begin
            hs_q        <= i_hs;
            vs_q        <= i_vs;
            de_q        <= i_blank_n;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            h_per_q     <= h_per_d;
            h_seen_q    <= h_seen_d;
            frame_bad_q <= frame_bad_d;
        end
    end

    // Lock state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock next-state: frame checks at VS fall, line errors drop lock at once
    always_comb begin
        state_d   = state_q;
        lock_loss = 1'b0;
        case (state_q)
            S_SEARCH: begin
                if (vs_fall) begin
                    state_d = S_ACQ;
                end
            end
            S_ACQ: begin
                if (vs_fall && frame_ok) begin
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                if (line_err || (vs_fall && !frame_ok)) begin
                    state_d   = S_ACQ;
                    lock_loss = 1'b1;
                end
            end
            default: state_d = S_SEARCH;
        endcase
    end

    // Pixel qualification and strobes; overlong lines and extra rows are dropped
    always_comb begin
        pix_valid = (state_q != S_SEARCH) && i_blank_n && (px < WidthC) && (py < HeightC);
        pix_sof   = pix_valid && (px == '0) && (py == '0);
        pix_eol   = pix_valid && (px == LastXC);
    end

    // Registered outputs, one cycle behind the input sample
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid   <= 1'b0;
            o_x       <= '0;
            o_y       <= '0;
            o_r       <= '0;
            o_g       <= '0;
            o_b       <= '0;
            o_sof     <= 1'b0;
            o_eol     <= 1'b0;
            o_locked  <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            o_valid  <= pix_valid;
            o_r      <= pix_valid ? i_r : 8'h00;
            o_g      <= pix_valid ? i_g : 8'h00;
            o_b      <= pix_valid ? i_b : 8'h00;
            o_sof    <= pix_sof;
            o_eol    <= pix_eol;
            o_locked <= (state_d == S_LOCK);
            if (pix_valid) begin
                o_x <= px;
                o_y <= py;
            end
            if (lock_loss && (o_err_cnt != 8'hFF)) begin
                o_err_cnt <= o_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Bench for vga_rx_decoder on a scaled-down video mode. A line/frame generator
// drives the link and a frame-level model predicts pixels, lock and error count.
module tb_vga_rx_decoder;

    localparam int WIDTH   = 8;
    localparam int HEIGHT  = 4;
    localparam int H_TOTAL = 16;
    localparam int CNT_W   = 11;
    localparam int HS_SYNC = 3;
    localparam int HS_BP   = 3;
    localparam int V_SYNC  = 1;
    localparam int V_BP    = 1;
    localparam int V_FP    = 1;
    localparam int NONE    = -1;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_hs, i_vs, i_blank_n;
    logic [7:0]       i_r, i_g, i_b;
    logic             o_valid;
    logic [CNT_W-1:0] o_x, o_y;
    logic [7:0]       o_r, o_g, o_b;
    logic             o_sof, o_eol, o_locked;
    logic [7:0]       o_err_cnt;

    vga_rx_decoder #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .H_TOTAL(H_TOTAL),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_hs     (i_hs),
        .i_vs     (i_vs),
        .i_blank_n(i_blank_n),
        .i_r      (i_r),
        .i_g      (i_g),
        .i_b      (i_b),
        .o_valid  (o_valid),
        .o_x      (o_x),
        .o_y      (o_y),
        .o_r      (o_r),
        .o_g      (o_g),
        .o_b      (o_b),
        .o_sof    (o_sof),
        .o_eol    (o_eol),
        .o_locked (o_locked),
        .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 = searching, 1 = acquiring, 2 = locked
    int m_state    = 0;
    int m_err      = 0;
    bit hs_seen    = 0;
    int prev_len   = 0;
    bit frame_good = 1;
    int vcnt, sof_cnt, eol_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One pixel clock: apply inputs, advance model, check outputs after the edge
    task automatic drive(input logic hs, input logic vs, input logic de, input int x,
                         input int y, input bit vsf, input bit lerr);
        bit         ev, ok;
        logic [7:0] bval, rval, gval;
        bval = 8'($urandom);
        rval = de ? 8'(x) : 8'($urandom);
        gval = de ? 8'(y) : 8'($urandom);
        i_hs = hs; i_vs = vs; i_blank_n = de;
        i_r = rval; i_g = gval; i_b = bval;

        ev = (m_state != 0) && de && (x < WIDTH) && (y < HEIGHT);
        ok = frame_good && !lerr;
        if (m_state == 2 && (lerr || (vsf && !ok))) begin
            m_state = 1;
            if (m_err < 255) m_err++;
        end else if (vsf) begin
            if (m_state == 0) m_state = 1;
            else if (m_state == 1 && ok) m_state = 2;
        end
        if (vsf) frame_good = 1;
        else if (lerr) frame_good = 0;

        @(posedge clk);
        #1;
        check("valid", o_valid, ev);
        check("locked", o_locked, m_state == 2);
        check("err_cnt", o_err_cnt, m_err);
        if (ev) begin
            check("x", o_x, x);
            check("y", o_y, y);
            check("r", o_r, rval);
            check("g", o_g, gval);
            check("b", o_b, bval);
            check("sof", o_sof, (x == 0) && (y == 0));
            check("eol", o_eol, x == WIDTH - 1);
        end else begin
            check("rgb_idle", {o_r, o_g, o_b}, 0);
            check("strobe_idle", {o_sof, o_eol}, 0);
        end
        if (o_valid) vcnt++;
        if (o_sof) sof_cnt++;
        if (o_eol) eol_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_hs = 1'b1; i_vs = 1'b1; i_blank_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_xy", {o_x, o_y}, 0);
        check("rst_rgb", {o_r, o_g, o_b}, 0);
        check("rst_strobes", {o_sof, o_eol, o_locked}, 0);
        check("rst_err", o_err_cnt, 0);
        rst = 1'b0;
        m_state = 0; m_err = 0; hs_seen = 0; frame_good = 1;
    endtask

    // One line: HS sync, back porch, n_pix active pixels, front porch up to len clocks
    task automatic line(input bit vs_low, input bit vsf, input int n_pix, input int len,
                        input int y);
        bit   lerr;
        logic de;
        for (int c = 0; c < len; c++) begin
            lerr = 0;
            if (c == 0) begin
                lerr = hs_seen && (prev_len != H_TOTAL);
                hs_seen = 1;
                prev_len = len;
            end
            if (n_pix > 0 && c == HS_SYNC + HS_BP + n_pix && n_pix != WIDTH) lerr = 1;
            de = (c >= HS_SYNC + HS_BP) && (c < HS_SYNC + HS_BP + n_pix);
            drive(c >= HS_SYNC, !vs_low, de, c - HS_SYNC - HS_BP, y, vsf && (c == 0), lerr);
        end
    endtask

    // One frame starting with the VS fall; fault knobs select a line index or NONE
    task automatic frame(input int n_act, input int short_at, input int long_at,
                         input int wide_at, input int rst_at);
        int npix;
        for (int v = 0; v < V_SYNC; v++) line(1'b1, v == 0, 0, H_TOTAL, 0);
        for (int v = 0; v < V_BP; v++) line(1'b0, 1'b0, 0, H_TOTAL, 0);
        for (int k = 0; k < n_act; k++) begin
            if (k == rst_at) do_reset();
            npix = (k == short_at) ? WIDTH - 1 : (k == wide_at) ? WIDTH + 1 : WIDTH;
            line(1'b0, 1'b0, npix, (k == long_at) ? H_TOTAL + 1 : H_TOTAL, k);
        end
        for (int v = 0; v < V_FP; v++) line(1'b0, 1'b0, 0, H_TOTAL, 0);
        if (n_act != HEIGHT) frame_good = 0;
    endtask

    task automatic clean_frame();
        frame(HEIGHT, NONE, NONE, NONE, NONE);
    endtask

    initial begin
        rst = 1'b1; i_hs = 1'b1; i_vs = 1'b1; i_blank_n = 1'b0;
        i_r = '0; i_g = '0; i_b = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // Nominal: search, acquire, lock; per-frame pixel and strobe counts
        for (int f = 0; f < 3; f++) begin
            vcnt = 0; sof_cnt = 0; eol_cnt = 0;
            clean_frame();
            check("pix_per_frame", vcnt, WIDTH * HEIGHT);
            check("sof_per_frame", sof_cnt, 1);
            check("eol_per_frame", eol_cnt, HEIGHT);
        end
        check("locked_nominal", o_locked, 1);

        // Short line while locked, then relock after one clean frame
        frame(HEIGHT, $urandom_range(HEIGHT - 1, 0), NONE, NONE, NONE);
        check("err_after_short", o_err_cnt, 1);
        clean_frame();
        check("unlocked_bad_frame", o_locked, 0);
        clean_frame();
        clean_frame();
        check("relock_after_short", o_locked, 1);

        // Extra and overlong lines while acquiring
        do_reset();
        frame(HEIGHT + 1, NONE, NONE, $urandom_range(HEIGHT - 1, 0), NONE);
        clean_frame();
        check("acq_extra_unlocked", o_locked, 0);
        clean_frame();
        check("relock_after_extra", o_locked, 1);

        // Long HS period while locked
        frame(HEIGHT, NONE, $urandom_range(HEIGHT - 1, 0), NONE, NONE);
        check("err_after_long_hs", o_err_cnt, 1);
        clean_frame();
        clean_frame();
        check("relock_after_long_hs", o_locked, 1);

        // Reset in the middle of a frame
        frame(HEIGHT, NONE, NONE, NONE, HEIGHT / 2);
        check("unlocked_after_rst", o_locked, 0);
        clean_frame();
        clean_frame();
        check("relock_after_rst", o_locked, 1);

        // Repeated lock loss via frames without active lines
        for (int i = 0; i < 300; i++) begin
            frame(0, NONE, NONE, NONE, NONE);
            clean_frame();
        end
        check("err_saturated", o_err_cnt, 255);
        clean_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
